// File: rtl/masked_pkg.sv
// Shared helpers for the masked ISW AND gadget: random-pair indexing
// and pipeline depth.
package masked_pkg;

   localparam int LATENCY = 3;

   // Fresh random bits needed per lane for a given share count.
   function automatic int nrand(input int shares);
      return shares * (shares - 1) / 2;
   endfunction

   // Index of pair (i,j), i<j, into the randomness vector.
   function automatic int pair_idx(input int i, input int j);
      return j * (j - 1) / 2 + i;
   endfunction

endpackage

// File: rtl/isw_lane.sv
// One bit-lane of the ISW AND gadget: cross-product, compression and
// output registers.
// Ports: clk, reset (async active-low), adv (global advance),
//        acc (load new shares), a/b/r (lane shares and randomness),
//        c (registered output shares).
module isw_lane
   import masked_pkg::*;
#(
   parameter int SHARES = 5,
   parameter int NR     = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              adv,
   input  logic              acc,
   input  logic [SHARES-1:0] a,
   input  logic [SHARES-1:0] b,
   input  logic [NR-1:0]     r,
   output logic [SHARES-1:0] c
);

   logic [NR-1:0]     za_n, zb_n;
   logic [NR-1:0]     za_q, zb_q, rq1_q;
   logic [NR-1:0]     z_q, rq2_q;
   logic [SHARES-1:0] d1_q, d2_q, c_n;

   // Each pair's two cross products go to separate registers so they
   // are never combined before a register boundary.
   always_comb begin
      za_n = '0;
      zb_n = '0;
      for (int j = 1; j < SHARES; j++) begin
         for (int i = 0; i < j; i++) begin
            za_n[pair_idx(i, j)] = r[pair_idx(i, j)] ^ (a[i] & b[j]);
            zb_n[pair_idx(i, j)] = a[j] & b[i];
         end
      end
   end

   // Row i takes the raw random bit of each pair it owns (j>i) and the
   // refreshed sum of each pair owned by an earlier row (j<i).
   always_comb begin
      c_n = d2_q;
      for (int j = 1; j < SHARES; j++) begin
         for (int i = 0; i < j; i++) begin
            c_n[i] = c_n[i] ^ rq2_q[pair_idx(i, j)];
            c_n[j] = c_n[j] ^ z_q[pair_idx(i, j)];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         za_q  <= '0;
         zb_q  <= '0;
         rq1_q <= '0;
         d1_q  <= '0;
         z_q   <= '0;
         rq2_q <= '0;
         d2_q  <= '0;
         c     <= '0;
      end else if (adv) begin
         // Bubbles load zero so no stale shares linger in stage 1.
         if (acc) begin
            za_q  <= za_n;
            zb_q  <= zb_n;
            rq1_q <= r;
            d1_q  <= a & b;
         end else begin
            za_q  <= '0;
            zb_q  <= '0;
            rq1_q <= '0;
            d1_q  <= '0;
         end
         z_q   <= za_q ^ zb_q;
         rq2_q <= rq1_q;
         d2_q  <= d1_q;
         c     <= c_n;
      end
   end

endmodule

// File: rtl/masked_and_isw_pipe.sv
// Order-ORDER ISW masked AND over WIDTH bit-sliced lanes with a
// valid/ready stream and a randomness-valid qualifier.
// Ports: clk, reset (async active-low), port_a/port_b (share i at
//        [i*WIDTH +: WIDTH]), port_r (pair k at [k*WIDTH +: WIDTH]),
//        in_valid, rand_valid, in_ready, port_c, out_valid, out_ready.
module masked_and_isw_pipe
   import masked_pkg::*;
#(
   parameter int ORDER = 4,
   parameter int WIDTH = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [(ORDER+1)*WIDTH-1:0]    port_a,
   input  logic [(ORDER+1)*WIDTH-1:0]    port_b,
   input  logic [nrand(ORDER+1)*WIDTH-1:0] port_r,
   input  logic                          in_valid,
   input  logic                          rand_valid,
   output logic                          in_ready,
   output logic [(ORDER+1)*WIDTH-1:0]    port_c,
   output logic                          out_valid,
   input  logic                          out_ready
);

   localparam int SHARES = ORDER + 1;
   localparam int NRAND  = nrand(SHARES);

   logic adv, acc;
   logic v1, v2;

   // One global advance: bubbles are not squeezed out under stall.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign acc      = in_valid && rand_valid && adv;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
      end else if (adv) begin
         v1        <= acc;
         v2        <= v1;
         out_valid <= v2;
      end
   end

   for (genvar w = 0; w < WIDTH; w++) begin : g_lane
      logic [SHARES-1:0] la, lb, lc;
      logic [NRAND-1:0]  lr;

      for (genvar i = 0; i < SHARES; i++) begin : g_sh
         assign la[i]             = port_a[i*WIDTH+w];
         assign lb[i]             = port_b[i*WIDTH+w];
         assign port_c[i*WIDTH+w] = lc[i];
      end

      for (genvar k = 0; k < NRAND; k++) begin : g_rnd
         assign lr[k] = port_r[k*WIDTH+w];
      end

      isw_lane #(
         .SHARES (SHARES),
         .NR     (NRAND)
      ) u_lane (
         .clk   (clk),
         .reset (reset),
         .adv   (adv),
         .acc   (acc),
         .a     (la),
         .b     (lb),
         .r     (lr),
         .c     (lc)
      );
   end

endmodule

// File: doc/masked_and_isw_pipe.md
Name: masked_and_isw_pipe

Overview:
- Parametrised ISW masked AND gadget of arbitrary protection order ORDER, operating on WIDTH parallel bit-sliced lanes.
- Adds a valid/ready stream interface with back-pressure, and a randomness-valid qualifier so that an operation never proceeds without fresh masks.
- Keeps the three-register-stage structure of the fixed order-4 gadget: cross-product register, compression register, output register.
- Sits between masked S-box linear layers and the fresh-randomness source in masked cipher datapaths.

Parameters:
- ORDER, 4, protection order d; SHARES = ORDER+1.
- WIDTH, 1, independent bit lanes processed in parallel.
- Derived (not overridable): NRAND = SHARES*(SHARES-1)/2, random bits per lane.

Ports:
- clk  in  1  clock; all registers rising-edge.
- reset  in  1  asynchronous, active-low reset.
- port_a  in  SHARES*WIDTH  shares of a; share i occupies bits [i*WIDTH +: WIDTH].
- port_b  in  SHARES*WIDTH  shares of b; same layout as port_a.
- port_r  in  NRAND*WIDTH  fresh randomness; pair index k occupies [k*WIDTH +: WIDTH].
- in_valid  in  1  port_a/port_b are valid.
- rand_valid  in  1  port_r is fresh.
- in_ready  out  1  gadget can advance.
- port_c  out  SHARES*WIDTH  output shares of a AND b.
- out_valid  out  1  port_c valid.
- out_ready  in  1  downstream accepts.

Behaviour:
- Randomness mapping: pair (i,j) with i<j uses r index k = j*(j-1)/2 + i. For d=4 this gives (0,1)=0, (0,2)=1, (1,2)=2, (0,3)=3, ..., (3,4)=9.
- Global advance: adv = !out_valid || out_ready. When adv=0, every register holds, including delayed randomness.
- in_ready = adv. This is combinational and independent of in_valid and rand_valid.
- Accept: acc = in_valid && rand_valid && adv.
  - Input is consumed only on acc.
  - in_valid && !rand_valid inserts a bubble: stage-1 valid is 0 and stage-1 data registers are loaded with zero (no stale shares retained).
- Stage 1 (on adv), per lane:
  - zA[i][j] = r_k ^ (a_i & b_j).
  - zB[i][j] = a_j & b_i.
  - d_i = a_i & b_i.
  - rq_k = r_k.
  - v1 = acc.
- Stage 2 (on adv): z[i][j] = zA ^ zB; d and rq are delayed one more stage; v2 = v1. The two products of each pair are never combined before a register.
- Stage 3 (on adv): c_i = d_i ^ XOR over j>i of rq(i,j) ^ XOR over j<i of z[j][i]; out_valid = v2.
- Latency: exactly 3 advancing cycles from acceptance to out_valid. Throughput is 1 result per cycle with no stall.
- Back-pressure: when out_valid=1 and out_ready=0, the pipeline freezes.
  - Bubbles inside the pipe are not compressed; advance is global.
  - A transfer occurs on out_valid && out_ready.
- Reset (async assert, any cycle, including mid-operation): all data registers clear to 0, v1/v2/out_valid clear to 0, and port_c reads 0.
  - in_ready is 1 after reset.
  - Deassertion is used as-is; the upstream synchroniser is not part of this block.
- Correctness invariant: XOR of the port_c shares = (XOR of a shares) & (XOR of b shares), per lane.
- No combinational path from port_a, port_b or port_r to any output.

Decomposition:
- Package masked_pkg:
  - function nrand(shares).
  - function pair_idx(i,j) implementing j*(j-1)/2 + i.
  - localparam LATENCY = 3.
- Sub-module isw_lane: one bit-lane with the three stages, sharing the adv and acc enables.
  - Instantiated WIDTH times by a generate loop.
  - Valid/ready logic lives only in the top module.

Test Plan:
- ORDER=4, WIDTH=1, port_a=5'b00001, port_b=5'b00001, port_r=0, in_valid=rand_valid=1, out_ready=1 -> port_c=5'b00001 with out_valid high on the 3rd cycle after acceptance; out_valid=0 before that.
- Same a/b, port_r=10'h3FF -> port_c=5'b00001 (XOR of shares = 1). Then a=5'b00011 (unmasked 0), b=5'b00001, any r -> XOR of port_c shares = 0.
- 20 back-to-back random vectors, out_ready=1 -> 20 consecutive out_valid cycles, each unmasked result equal to a&b, in order.
- out_ready=0 for 5 cycles with 3 items in flight -> port_c and out_valid frozen, in_ready=0. On release, the remaining items emerge one per cycle, no loss or duplication.
- in_valid=1, rand_valid=0 for 2 cycles -> no acceptance, no out_valid for those slots, stage registers zero.
- Assert reset (low) mid-flight with 2 items in flight -> out_valid=0 and port_c=0 immediately. After release, the first new item appears exactly 3 cycles after acceptance.
- Regression for ORDER=1, 2, 7 and WIDTH=8, run with VERICA random-probing: XOR-of-shares correctness holds across all configurations.
